painterengine_gpu_display_fetcher: RTL and testbench
====================================================

// Module: painterengine_gpu_display_fetcher
// PURPOSE
//  Parametrised frame-fetch sequencer for the display path. It walks a clipped window of a
//  framebuffer line by line and issues DMA-reader bursts, with programmable stride, pan offset,
//  bytes-per-pixel and free-running multi-frame mode. It sits between the register file and the
//  DMA reader, in the write-clock domain only. The DVI FIFO and pixel timing live outside it.
// PARAMETERS
//  ADDR_W      32   width of every byte address
//  COORD_W     16   width of the x/y/width/height/offset fields
//  BURST_MAX   64   maximum pixels per reader burst (>=1)
//  FIFO_DEPTH  128  depth of the downstream FIFO, in pixels
//  BPP_BYTES   4    bytes per pixel; must be a power of 2
//  CNT_W = $clog2(FIFO_DEPTH+1) (localparam)
// PORTS
//  i_wire_clock             in   1        system clock
//  i_wire_resetn            in   1        synchronous reset, active-low
//  i_wire_start             in   1        1-cycle pulse: start a frame; also clears a sticky error
//  i_wire_continuous        in   1        1: restart automatically after each frame
//  i_wire_base_address      in   ADDR_W   framebuffer byte address of pixel (0,0)
//  i_wire_stride_bytes      in   32       byte distance between consecutive source lines
//  i_wire_offset_x/_y       in   COORD_W  pan offset of the window inside the source image
//  i_wire_width/_height     in   COORD_W  window size in pixels; already clipped upstream
//  i_wire_fifo_free_count   in   CNT_W    free FIFO entries
//  o_wire_reader_address    out  ADDR_W   burst start byte address
//  o_wire_reader_length     out  32       burst length in pixels
//  o_wire_reader_resetn     out  1        1 = reader runs; 0 = reader held/reset
//  i_wire_reader_done       in   1        burst complete
//  i_wire_reader_error      in   1        burst failed
//  o_wire_busy              out  1        high in every state except IDLE and ERROR
//  o_wire_frame_done        out  1        1-cycle pulse when the last burst of a frame completes
//  o_wire_error             out  1        sticky; high in ERROR
//  o_wire_state             out  3        IDLE=0 LATCH=1 CALC=2 WAIT=3 STREAM=4 NEXT=5 ERROR=7
//  o_wire_line              out  COORD_W  current window line (y)
// BEHAVIOUR
//  - Reset (synchronous, resetn=0 at a clock edge): state=IDLE, x=y=0, all outputs 0. This applies
//    mid-burst too: reader_resetn drops on the same edge.
//  - IDLE: on start go to LATCH. start is ignored in every other state except ERROR.
//  - LATCH: shadow-copy base, stride, offsets, width and height. The inputs may change freely
//    afterwards; the frame uses only the shadows. x=y=0.
//    If width==0 or height==0: pulse frame_done and return to IDLE, or stay in LATCH if continuous.
//    Otherwise go to CALC.
//  - CALC (1 cycle):
//    addr = base + (off_y+y)*stride + (off_x+x)*BPP_BYTES, computed mod 2^ADDR_W.
//    len  = min(BURST_MAX, width-x), zero-extended to 32 bits.
//    Go to WAIT.
//  - WAIT: hold until fifo_free_count >= len, then go to STREAM. There is no timeout.
//  - STREAM: reader_resetn=1. Address and length stay stable for the whole burst.
//    error -> ERROR; error wins over a simultaneous done. done -> NEXT.
//  - NEXT (1 cycle): x += len.
//    If x+len==width: x=0, y++. If additionally y+1==height, this was the last burst: pulse
//    frame_done and go to LATCH if continuous, else IDLE. Otherwise go to CALC.
//  - reader_resetn is 0 in every state except STREAM. This gives at least 2 low cycles
//    (NEXT, CALC) between bursts.
//  - done and error are sampled only in STREAM; in any other state they are ignored.
//  - ERROR: reader held in reset, error=1. Leave only on start (-> LATCH, error cleared) or reset.
//  - Latency: start -> first reader_resetn=1 is 3 cycles, with enough FIFO space.
//    Burst done -> next burst open is 3 cycles (NEXT, CALC, WAIT).
// TESTING
//  - 8x2 window, base=0x1000, stride=64, BPP=4, offsets 0, free=128 -> bursts (0x1000,8),
//    (0x1040,8); then one frame_done pulse and IDLE.
//  - width=150, BURST_MAX=64 -> per line, lengths 64, 64, 22 at x*4 offsets 0, 256, 512;
//    y advances only after the 22-pixel burst.
//  - offset_x=3, offset_y=2, stride=1280 -> first address = base + 2*1280 + 12.
//  - free_count=10 with len=64 -> stays in WAIT with reader_resetn=0; raising free to 64 ->
//    STREAM on the next cycle.
//  - done and error together in STREAM -> ERROR, error=1, no frame_done; a start pulse then ->
//    LATCH with error=0.
//  - Continuous mode, height=1 -> back-to-back frames; each frame_done pulse is 1 cycle.
//    Changing base mid-frame takes effect only from the next frame. resetn=0 mid-burst -> IDLE
//    with all outputs 0 on the same edge.

Source files
------------

// File: rtl/painterengine_gpu_display_fetcher.sv
// Display frame-fetch sequencer.
// Walks a panned, clipped window of a framebuffer line by line and hands
// one burst at a time to the DMA reader. Frame geometry is shadowed when the
// frame starts, so the register file may be reprogrammed while a frame runs.
//
// Reader handshake: address/length are registered in CALC and stay constant
// while reader_resetn is high (STREAM only). The reader signals completion
// with done or failure with error. Both are looked at only in STREAM, and
// error takes priority. reader_resetn is low in every other state, which
// separates consecutive bursts by at least NEXT and CALC.
module painterengine_gpu_display_fetcher #(
  parameter int ADDR_W     = 32,
  parameter int COORD_W    = 16,
  parameter int BURST_MAX  = 64,
  parameter int FIFO_DEPTH = 128,
  parameter int BPP_BYTES  = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               i_wire_clock,
  input  logic               i_wire_resetn,
  input  logic               i_wire_start,
  input  logic               i_wire_continuous,
  input  logic [ADDR_W-1:0]  i_wire_base_address,
  input  logic [31:0]        i_wire_stride_bytes,
  input  logic [COORD_W-1:0] i_wire_offset_x,
  input  logic [COORD_W-1:0] i_wire_offset_y,
  input  logic [COORD_W-1:0] i_wire_width,
  input  logic [COORD_W-1:0] i_wire_height,
  input  logic [CNT_W-1:0]   i_wire_fifo_free_count,
  output logic [ADDR_W-1:0]  o_wire_reader_address,
  output logic [31:0]        o_wire_reader_length,
  output logic               o_wire_reader_resetn,
  input  logic               i_wire_reader_done,
  input  logic               i_wire_reader_error,
  output logic               o_wire_busy,
  output logic               o_wire_frame_done,
  output logic               o_wire_error,
  output logic [2:0]         o_wire_state,
  output logic [COORD_W-1:0] o_wire_line
);

  // Pixel size is a power of two, so the column term is a shift.
  localparam int BPP_SHIFT = $clog2(BPP_BYTES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CALC   = 3'd2,
    S_WAIT   = 3'd3,
    S_STREAM = 3'd4,
    S_NEXT   = 3'd5,
    S_ERROR  = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Frame shadows, captured in LATCH
  logic [ADDR_W-1:0]  base_q;
  logic [31:0]        stride_q;
  logic [COORD_W-1:0] off_x_q, off_y_q, width_q, height_q;

  // Window walk position and the current burst
  logic [COORD_W-1:0] x_q, y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        len_q;

  // Derived values
  logic [ADDR_W-1:0] row_a, col_a, calc_addr;
  logic [31:0]       remain, calc_len, x_end;
  logic              line_end, frame_end, zero_size;

  // Burst address/length for the current (x,y) and end-of-line/frame tests
  always_comb begin
    row_a     = ADDR_W'(off_y_q) + ADDR_W'(y_q);
    col_a     = ADDR_W'(off_x_q) + ADDR_W'(x_q);
    calc_addr = base_q + row_a * ADDR_W'(stride_q) + (col_a << BPP_SHIFT);
    remain    = 32'(width_q) - 32'(x_q);
    calc_len  = (remain > 32'(BURST_MAX)) ? 32'(BURST_MAX) : remain;
    x_end     = 32'(x_q) + len_q;
    line_end  = (x_end == 32'(width_q));
    frame_end = line_end && ((32'(y_q) + 32'd1) == 32'(height_q));
    zero_size = (i_wire_width == '0) || (i_wire_height == '0);
  end

  // State register
  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_d              = state_q;
    o_wire_frame_done    = 1'b0;
    o_wire_reader_resetn = 1'b0;
    o_wire_busy          = 1'b1;
    o_wire_error         = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_wire_busy = 1'b0;
        if (i_wire_start) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (zero_size) begin
          o_wire_frame_done = 1'b1;
          state_d = i_wire_continuous ? S_LATCH : S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: state_d = S_WAIT;
      S_WAIT: begin
        if (32'(i_wire_fifo_free_count) >= len_q) state_d = S_STREAM;
      end
      S_STREAM: begin
        o_wire_reader_resetn = 1'b1;
        if (i_wire_reader_error) state_d = S_ERROR;
        else if (i_wire_reader_done) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (frame_end) begin
          o_wire_frame_done = 1'b1;
          state_d = i_wire_continuous ? S_LATCH : S_IDLE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_ERROR: begin
        o_wire_busy  = 1'b0;
        o_wire_error = 1'b1;
        if (i_wire_start) state_d = S_LATCH;
      end
      default: begin
        o_wire_busy = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Shadow capture, burst registration and window walk
  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      base_q   <= '0;
      stride_q <= '0;
      off_x_q  <= '0;
      off_y_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      len_q    <= '0;
    end else begin
      case (state_q)
        S_LATCH: begin
          base_q   <= i_wire_base_address;
          stride_q <= i_wire_stride_bytes;
          off_x_q  <= i_wire_offset_x;
          off_y_q  <= i_wire_offset_y;
          width_q  <= i_wire_width;
          height_q <= i_wire_height;
          x_q      <= '0;
          y_q      <= '0;
        end
        S_CALC: begin
          addr_q <= calc_addr;
          len_q  <= calc_len;
        end
        S_NEXT: begin
          if (line_end) begin
            x_q <= '0;
            y_q <= y_q + COORD_W'(1);
          end else begin
            x_q <= x_q + COORD_W'(len_q);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_wire_reader_address = addr_q;
  assign o_wire_reader_length  = len_q;
  assign o_wire_state          = state_q;
  assign o_wire_line           = y_q;

endmodule

// File: tb/tb_painterengine_gpu_display_fetcher.sv
// Bench for the display frame-fetch sequencer: a reader model answers bursts
// with random delays, and a window-walk model predicts every burst.
module tb_painterengine_gpu_display_fetcher;

  localparam int ADDR_W     = 32;
  localparam int COORD_W    = 16;
  localparam int BURST_MAX  = 64;
  localparam int FIFO_DEPTH = 128;
  localparam int BPP_BYTES  = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LATCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_STREAM = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  // Clock / reset
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               i_resetn, i_start, i_continuous;
  logic [ADDR_W-1:0]  i_base;
  logic [31:0]        i_stride;
  logic [COORD_W-1:0] i_ox, i_oy, i_w, i_h;
  logic [CNT_W-1:0]   i_free;
  logic               i_done, i_err;
  logic [ADDR_W-1:0]  o_addr;
  logic [31:0]        o_len;
  logic               o_rstn, o_busy, o_fd, o_error;
  logic [2:0]         o_state;
  logic [COORD_W-1:0] o_line;

  painterengine_gpu_display_fetcher #(
    .ADDR_W(ADDR_W), .COORD_W(COORD_W), .BURST_MAX(BURST_MAX),
    .FIFO_DEPTH(FIFO_DEPTH), .BPP_BYTES(BPP_BYTES)
  ) dut (
    .i_wire_clock(clk),
    .i_wire_resetn(i_resetn),
    .i_wire_start(i_start),
    .i_wire_continuous(i_continuous),
    .i_wire_base_address(i_base),
    .i_wire_stride_bytes(i_stride),
    .i_wire_offset_x(i_ox),
    .i_wire_offset_y(i_oy),
    .i_wire_width(i_w),
    .i_wire_height(i_h),
    .i_wire_fifo_free_count(i_free),
    .o_wire_reader_address(o_addr),
    .o_wire_reader_length(o_len),
    .o_wire_reader_resetn(o_rstn),
    .i_wire_reader_done(i_done),
    .i_wire_reader_error(i_err),
    .o_wire_busy(o_busy),
    .o_wire_frame_done(o_fd),
    .o_wire_error(o_error),
    .o_wire_state(o_state),
    .o_wire_line(o_line)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_len_q[$];
  logic [31:0] exp_line_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Frame configuration
  logic [31:0] cfg_base, cfg_stride;
  int cfg_ox, cfg_oy, cfg_w, cfg_h;

  task automatic apply_cfg();
    i_base   = cfg_base;
    i_stride = cfg_stride;
    i_ox     = COORD_W'(cfg_ox);
    i_oy     = COORD_W'(cfg_oy);
    i_w      = COORD_W'(cfg_w);
    i_h      = COORD_W'(cfg_h);
  endtask

  // Reference: walk the window, cutting each line into bursts of at most BURST_MAX
  function automatic int build_expected(input int frames, input logic [31:0] base);
    int n, x, len;
    logic [31:0] a;
    n = 0;
    for (int f = 0; f < frames; f++) begin
      for (int y = 0; y < cfg_h; y++) begin
        x = 0;
        while (x < cfg_w) begin
          len = (cfg_w - x > BURST_MAX) ? BURST_MAX : cfg_w - x;
          a = base + 32'(cfg_oy + y) * cfg_stride + 32'((cfg_ox + x) * BPP_BYTES);
          exp_addr_q.push_back(a);
          exp_len_q.push_back(32'(len));
          exp_line_q.push_back(32'(y));
          x += len;
          n++;
        end
      end
    end
    return n;
  endfunction

  // Reader / FIFO model state
  int cyc = 0, start_cyc = 0, first_open_cyc = -1, last_done_cyc = -1;
  int bursts_seen = 0, fd_count = 0, dly = 0;
  bit open_b = 0, prev_fd = 0, pend_valid = 0;
  bit free_mode = 0, noise_en = 0, hold_done = 0, measure_gap = 0;
  logic [2:0]  pend_state = 3'd0;
  logic [31:0] open_addr, open_len;
  logic [CNT_W-1:0] fixed_free = CNT_W'(FIFO_DEPTH);

  // One cycle: sample at the falling edge, then drive the next inputs
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pend_valid) begin
      check_eq("wait_exit", o_state, pend_state);
      pend_valid = 0;
    end
    if (o_fd) begin
      fd_count++;
      check_eq("frame_done_1cyc", prev_fd, 0);
    end
    prev_fd = o_fd;
    i_done = 1'b0;
    i_err  = 1'b0;
    if (o_rstn) begin
      if (!open_b) begin
        open_b = 1;
        bursts_seen++;
        dly = $urandom_range(0, 3);
        if (first_open_cyc < 0) first_open_cyc = cyc;
        if (measure_gap && last_done_cyc >= 0) check_eq("burst_gap", cyc - last_done_cyc - 1, 3);
        if (exp_addr_q.size() > 0) begin
          open_addr = exp_addr_q.pop_front();
          open_len  = exp_len_q.pop_front();
          check_eq("burst_addr", o_addr, open_addr);
          check_eq("burst_len", o_len, open_len);
          check_eq("burst_line", o_line, exp_line_q.pop_front());
        end
      end
      if (!hold_done) begin
        if (dly == 0) begin
          check_eq("addr_stable", o_addr, open_addr);
          check_eq("len_stable", o_len, open_len);
          i_done = 1'b1;
          last_done_cyc = cyc;
        end else begin
          dly--;
        end
      end
    end else begin
      open_b = 0;
      if (noise_en) begin
        i_done = 1'($urandom_range(0, 1));
        i_err  = ($urandom_range(0, 3) == 0);
      end
    end
    i_free = free_mode ? CNT_W'($urandom_range(0, FIFO_DEPTH)) : fixed_free;
    if (o_state == ST_WAIT && exp_len_q.size() > 0) begin
      pend_valid = 1;
      pend_state = (32'(i_free) >= exp_len_q[0]) ? ST_STREAM : ST_WAIT;
    end
  endtask

  task automatic pulse_start();
    fd_count = 0;
    bursts_seen = 0;
    first_open_cyc = -1;
    last_done_cyc = -1;
    pend_valid = 0;
    i_start = 1'b1;
    start_cyc = cyc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_frame(input int n_frames, input int n_bursts, input int budget, input string tag);
    int c;
    c = 0;
    while (!(fd_count >= n_frames && !open_b && exp_addr_q.size() == 0) && c < budget) begin
      tick();
      c++;
    end
    check_eq({tag, "_in_time"}, c < budget, 1);
    check_eq({tag, "_bursts"}, bursts_seen, n_bursts);
    check_eq({tag, "_frames"}, fd_count, n_frames);
  endtask

  task automatic expect_idle(input string tag);
    tick();
    check_eq({tag, "_state_idle"}, o_state, ST_IDLE);
    check_eq({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic flush_expected();
    exp_addr_q.delete();
    exp_len_q.delete();
    exp_line_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver / test sequence
  initial begin
    int n, c;
    logic [31:0] b1, b2;
    i_resetn = 1'b0; i_start = 1'b0; i_continuous = 1'b0;
    i_done = 1'b0; i_err = 1'b0; i_free = CNT_W'(FIFO_DEPTH);
    cfg_base = 32'h0; cfg_stride = 32'h0; cfg_ox = 0; cfg_oy = 0; cfg_w = 0; cfg_h = 0;
    apply_cfg();
    repeat (3) tick();
    check_eq("rst_state", o_state, ST_IDLE);
    check_eq("rst_rstn", o_rstn, 0);
    check_eq("rst_addr", o_addr, 0);
    check_eq("rst_len", o_len, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_err", o_error, 0);
    check_eq("rst_fd", o_fd, 0);
    check_eq("rst_line", o_line, 0);
    i_resetn = 1'b1;
    tick();

    // 8x2 window, plenty of FIFO space: latency and inter-burst gap
    cfg_base = 32'h1000; cfg_stride = 64; cfg_ox = 0; cfg_oy = 0; cfg_w = 8; cfg_h = 2;
    free_mode = 0; fixed_free = CNT_W'(FIFO_DEPTH); measure_gap = 1;
    n = build_expected(1, cfg_base);
    apply_cfg();
    pulse_start();
    run_frame(1, n, 200, "a");
    check_eq("a_start_latency", first_open_cyc - start_cyc - 1, 3);
    expect_idle("a");
    measure_gap = 0;

    // 150 pixels wide: lines split 64/64/22, random FIFO space and reader noise
    noise_en = 1; free_mode = 1;
    cfg_base = $urandom & 32'hFFFF_FFF0; cfg_stride = 1024; cfg_w = 150; cfg_h = 2;
    n = build_expected(1, cfg_base);
    apply_cfg();
    pulse_start();
    run_frame(1, n, 2000, "b");
    expect_idle("b");

    // Pan offsets
    cfg_base = 32'h2000; cfg_stride = 1280; cfg_ox = 3; cfg_oy = 2; cfg_w = 5; cfg_h = 3;
    n = build_expected(1, cfg_base);
    apply_cfg();
    pulse_start();
    run_frame(1, n, 2000, "c");
    expect_idle("c");

    // FIFO back-pressure holds WAIT until free >= len
    free_mode = 0; fixed_free = CNT_W'(10);
    cfg_base = 32'h8000; cfg_stride = 256; cfg_ox = 0; cfg_oy = 0; cfg_w = 64; cfg_h = 1;
    n = build_expected(1, cfg_base);
    apply_cfg();
    pulse_start();
    repeat (6) tick();
    check_eq("wait_hold_state", o_state, ST_WAIT);
    check_eq("wait_hold_rstn", o_rstn, 0);
    fixed_free = CNT_W'(64);
    tick();
    tick();
    check_eq("wait_release", o_state, ST_STREAM);
    run_frame(1, n, 200, "w");
    expect_idle("w");

    // done and error together: error wins, start clears it
    fixed_free = CNT_W'(FIFO_DEPTH); noise_en = 0;
    cfg_base = 32'h4000; cfg_stride = 128; cfg_w = 16; cfg_h = 2;
    n = build_expected(1, cfg_base);
    apply_cfg();
    hold_done = 1;
    pulse_start();
    c = 0;
    while (!open_b && c < 50) begin tick(); c++; end
    check_eq("e_open_in_time", c < 50, 1);
    i_done = 1'b1; i_err = 1'b1;
    tick();
    check_eq("e_state", o_state, ST_ERROR);
    check_eq("e_error", o_error, 1);
    check_eq("e_busy", o_busy, 0);
    hold_done = 0;
    noise_en = 1;
    repeat (3) tick();
    check_eq("e_sticky", o_state, ST_ERROR);
    check_eq("e_no_frame_done", fd_count, 0);
    flush_expected();
    n = build_expected(1, cfg_base);
    pulse_start();
    check_eq("e_restart_state", o_state, ST_LATCH);
    check_eq("e_restart_error", o_error, 0);
    run_frame(1, n, 500, "e");
    expect_idle("e");

    // Zero-size window: immediate frame_done
    cfg_w = 0; cfg_h = 5;
    n = build_expected(1, cfg_base);
    apply_cfg();
    pulse_start();
    run_frame(1, n, 50, "z");
    expect_idle("z");

    // Random windows
    free_mode = 1;
    for (int k = 0; k < 5; k++) begin
      cfg_base = $urandom; cfg_stride = 32'($urandom_range(1, 4096) * 4);
      cfg_ox = $urandom_range(0, 50); cfg_oy = $urandom_range(0, 50);
      cfg_w = $urandom_range(1, 140); cfg_h = $urandom_range(1, 3);
      n = build_expected(1, cfg_base);
      apply_cfg();
      pulse_start();
      run_frame(1, n, 3000, "r");
      expect_idle("r");
    end

    // Continuous frames; a base change lands on the following frame
    free_mode = 0; fixed_free = CNT_W'(FIFO_DEPTH);
    b1 = 32'h0001_0000; b2 = 32'h0002_0000;
    cfg_base = b1; cfg_stride = 512; cfg_ox = 1; cfg_oy = 1; cfg_w = 10; cfg_h = 1;
    n = build_expected(1, b1);
    n += build_expected(3, b2);
    apply_cfg();
    i_continuous = 1'b1;
    pulse_start();
    c = 0;
    while (fd_count < 3 && c < 500) begin
      tick();
      c++;
      if (bursts_seen >= 1) i_base = b2;
    end
    check_eq("cont_frames_in_time", c < 500, 1);
    hold_done = 1;
    c = 0;
    while (!(bursts_seen >= 4 && open_b) && c < 50) begin tick(); c++; end
    check_eq("cont_burst4_in_time", c < 50, 1);
    check_eq("cont_bursts", bursts_seen, n);
    check_eq("cont_q_empty", exp_addr_q.size(), 0);
    i_continuous = 1'b0;
    i_resetn = 1'b0;
    tick();
    check_eq("mid_rst_state", o_state, ST_IDLE);
    check_eq("mid_rst_rstn", o_rstn, 0);
    check_eq("mid_rst_addr", o_addr, 0);
    check_eq("mid_rst_len", o_len, 0);
    check_eq("mid_rst_busy", o_busy, 0);
    check_eq("mid_rst_line", o_line, 0);
    check_eq("mid_rst_fd", o_fd, 0);
    hold_done = 0;
    i_resetn = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
